// File: rtl/skyhop_pkg.sv
// Shared definitions for the SkyHop round sequencer: state codes, register
// widths and a counter-width helper.
package skyhop_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned MS_CNT_W = 12;
    localparam int unsigned LIVES_W  = 3;
    localparam int unsigned LEVEL_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        S_MENU   = 3'd0,
        S_READY  = 3'd1,
        S_PLAY   = 3'd2,
        S_LVL_UP = 3'd3,
        S_LOST   = 3'd4,
        S_OVER   = 3'd5
    } state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms prescaler; one_ms_tick is high for the cycle in which the
// count sits at its maximum.
module ms_tick_gen
    import skyhop_pkg::*;
#(
    parameter int unsigned CLK_HZ = 40_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic one_ms_tick
);

    localparam int unsigned P     = CLK_HZ / 1000;
    localparam int unsigned CNT_W = cnt_width(P);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Tick is registered from the next count so it lines up with cnt_q == max.
    always_comb begin
        cnt_d  = (cnt_q == CNT_W'(P - 1)) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_d == CNT_W'(P - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign one_ms_tick = tick_q;

endmodule

// File: rtl/game_round_ctrl.sv
// SkyHop round sequencer: owns the ms timebase, sequences the time bar and
// tracks lives, level and win/lose.
module game_round_ctrl
    import skyhop_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 40_000_000,
    parameter int unsigned READY_MS = 2000,
    parameter int unsigned PAUSE_MS = 1000,
    parameter int unsigned LIVES    = 3,
    parameter int unsigned LEVELS   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       player_fell,
    input  logic       level_done,
    input  logic       elapsed,
    output logic       bar_en,
    output logic       bar_start,
    output logic       one_ms_tick,
    output logic [2:0] state_out,
    output logic [2:0] lives,
    output logic [3:0] level,
    output logic       win
);

    state_e               state_q, state_d;
    logic [MS_CNT_W-1:0]  ms_cnt_q, ms_cnt_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic                 win_q, win_d;
    logic                 bar_en_q, bar_en_d;
    logic                 bar_start_q, bar_start_d;
    logic                 tick;
    logic                 ready_end, pause_end;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk         (clk),
        .rst         (rst),
        .one_ms_tick (tick)
    );

    assign ready_end = tick && (ms_cnt_q == MS_CNT_W'(READY_MS - 1));
    assign pause_end = tick && (ms_cnt_q == MS_CNT_W'(PAUSE_MS - 1));

    // Next-state, score updates and registered output decode.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        win_d   = win_q;

        case (state_q)
            S_MENU: begin
                if (btn_start) begin
                    lives_d = LIVES_W'(LIVES);
                    level_d = '0;
                    win_d   = 1'b0;
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (ready_end) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (level_done) begin
                    if (level_q == LEVEL_W'(LEVELS - 1)) begin
                        win_d   = 1'b1;
                        state_d = S_OVER;
                    end else begin
                        state_d = S_LVL_UP;
                    end
                end else if (player_fell || elapsed) begin
                    if (lives_q <= LIVES_W'(1)) begin
                        lives_d = '0;
                        state_d = S_OVER;
                    end else begin
                        lives_d = lives_q - LIVES_W'(1);
                        state_d = S_LOST;
                    end
                end
            end
            S_LVL_UP: begin
                if (pause_end) begin
                    if (level_q < LEVEL_W'(LEVELS - 1)) level_d = level_q + LEVEL_W'(1);
                    state_d = S_READY;
                end
            end
            S_LOST: begin
                if (pause_end) state_d = S_READY;
            end
            S_OVER: begin
                if (btn_start) state_d = S_MENU;
            end
            default: state_d = S_MENU;
        endcase

        // Dwell restarts on every state change.
        if (state_d != state_q) ms_cnt_d = '0;
        else if (tick)          ms_cnt_d = ms_cnt_q + MS_CNT_W'(1);
        else                    ms_cnt_d = ms_cnt_q;

        bar_en_d    = (state_d == S_READY) || (state_d == S_PLAY);
        bar_start_d = (state_d == S_PLAY) && (state_q != S_PLAY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_MENU;
            ms_cnt_q    <= '0;
            lives_q     <= LIVES_W'(LIVES);
            level_q     <= '0;
            win_q       <= 1'b0;
            bar_en_q    <= 1'b0;
            bar_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ms_cnt_q    <= ms_cnt_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            win_q       <= win_d;
            bar_en_q    <= bar_en_d;
            bar_start_q <= bar_start_d;
        end
    end

    assign bar_en      = bar_en_q;
    assign bar_start   = bar_start_q;
    assign one_ms_tick = tick;
    assign state_out   = state_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign win         = win_q;

endmodule
